univ_shift_reg: RTL

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

---
 rtl/univ_shift_reg.sv | 127 ++++++++++++
 1 files changed

// File: rtl/univ_shift_reg.sv
// Universal multi-step shift register: logical, arithmetic, rotate and
// serial-fill shifts in either direction, one bit per clock.
module univ_shift_reg #(
   parameter int WIDTH = 8,
   localparam int CW = $clog2(WIDTH+1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] in,
   input  logic             start,
   input  logic             dir,
   input  logic [1:0]       mode,
   input  logic [CW-1:0]    amt,
   input  logic             ser_in,
   output logic [WIDTH-1:0] q,
   output logic             ser_out,
   output logic             busy,
   output logic             done
);

   localparam logic [1:0] M_LOG = 2'b00;
   localparam logic [1:0] M_ARI = 2'b01;
   localparam logic [1:0] M_ROT = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_SHIFT = 2'b01,
      S_DONE  = 2'b10
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             dir_q, dir_d;
   logic [1:0]       mode_q, mode_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic             so_q, so_d;

   logic [CW-1:0]    eff_amt;
   logic             fill;
   logic [WIDTH-1:0] step_val;
   logic             out_bit;

   // Requests beyond the register width collapse to a full-width shift
   assign eff_amt = (amt > CW'(WIDTH)) ? CW'(WIDTH) : amt;

   always_comb begin
      fill = 1'b0;
      unique case (mode_q)
         M_LOG:   fill = 1'b0;
         M_ARI:   fill = dir_q ? 1'b0 : q_q[WIDTH-1];
         M_ROT:   fill = dir_q ? q_q[WIDTH-1] : q_q[0];
         default: fill = ser_in;
      endcase
   end

   always_comb begin
      step_val = '0;
      out_bit  = 1'b0;
      if (dir_q) begin
         step_val = {q_q[WIDTH-2:0], fill};
         out_bit  = q_q[WIDTH-1];
      end else begin
         step_val = {fill, q_q[WIDTH-1:1]};
         out_bit  = q_q[0];
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      mode_d  = mode_q;
      q_d     = q_q;
      so_d    = so_q;
      unique case (state_q)
         S_IDLE: begin
            if (load) begin
               q_d = in;
            end else if (start) begin
               dir_d   = dir;
               mode_d  = mode;
               cnt_d   = eff_amt;
               state_d = (eff_amt == '0) ? S_DONE : S_SHIFT;
            end
         end
         S_SHIFT: begin
            q_d   = step_val;
            so_d  = out_bit;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         dir_q   <= 1'b0;
         mode_q  <= 2'b00;
         q_q     <= '0;
         so_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
         mode_q  <= mode_d;
         q_q     <= q_d;
         so_q    <= so_d;
      end
   end

   assign q       = q_q;
   assign ser_out = so_q;
   assign busy    = (state_q == S_SHIFT);
   assign done    = (state_q == S_DONE);

endmodule
